// File: rtl/smi_pkg.sv
// Shared SMI definitions: field widths, frame type IDs, arbiter state encoding.
package smi_pkg;

  localparam int SmiEofcWidth = 8;

  // Frame type ID bytes carried in the first word of a frame.
  localparam logic [7:0] SmiFrameWriteResp = 8'hFE;

  typedef enum logic {
    ArbIdle    = 1'b0,
    ArbForward = 1'b1
  } arbState_t;

  // Any non-zero end-of-frame control marks the last word of a frame.
  function automatic logic smiIsEof(input logic [SmiEofcWidth-1:0] eofc);
    return eofc != '0;
  endfunction

endpackage

// File: rtl/smi_skid_buffer.sv
// Two-entry FIFO with registered full/empty flags. The head register drives
// the output directly, so nothing downstream reaches back into the writer.
//
// Handshake: a word enters when pushEn=1 and full=0, and leaves when
// popEn=1 and empty=0; both may happen in the same cycle.
module smi_skid_buffer #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             pushEn,
  input  logic [Width-1:0] pushData,
  input  logic             popEn,
  output logic [Width-1:0] headData,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] slot0_q;
  logic [Width-1:0] slot1_q;
  logic [1:0]       count_q;
  logic [1:0]       countNext;
  logic             full_q;
  logic             empty_q;
  logic             doPush;
  logic             doPop;

  // Qualify push/pop with the registered flags and derive the next occupancy.
  always_comb begin
    doPush    = pushEn && !full_q;
    doPop     = popEn && !empty_q;
    countNext = count_q;
    if (doPush && !doPop) begin
      countNext = count_q + 2'd1;
    end else if (doPop && !doPush) begin
      countNext = count_q - 2'd1;
    end
  end

  // Storage: slot0 is always the head; slot1 holds the second word when full.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      unique case ({doPush, doPop})
        2'b10: begin
          if (count_q == 2'd0) begin
            slot0_q <= pushData;
          end else begin
            slot1_q <= pushData;
          end
        end
        2'b01: begin
          slot0_q <= slot1_q;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            slot0_q <= pushData;
          end else begin
            slot0_q <= slot1_q;
            slot1_q <= pushData;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Occupancy and registered flags.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_q <= 2'd0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= countNext;
      full_q  <= (countNext == 2'd2);
      empty_q <= (countNext == 2'd0);
    end
  end

  assign headData = slot0_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/smi_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one SMI request channel between
// NumPorts requesters. A grant is held from a frame's first word until its
// EOF word is accepted; the granted port index travels with every word.
//
// Handshake: on every channel a word moves when Ready=1 and Stop=0 in the
// same cycle; Ready never waits for Stop.
import smi_pkg::*;

module smi_frame_arbiter #(
  parameter int NumPorts      = 4,
  parameter int PortIdWidth   = 2,
  parameter int DataIndexSize = 4,
  parameter int DataWidth     = (1 << DataIndexSize) * 8
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [NumPorts-1:0]             smiInReady,
  input  logic [NumPorts*SmiEofcWidth-1:0] smiInEofc,
  input  logic [NumPorts*DataWidth-1:0]   smiInData,
  output logic [NumPorts-1:0]             smiInStop,
  output logic                            smiOutReady,
  output logic [SmiEofcWidth-1:0]         smiOutEofc,
  output logic [DataWidth-1:0]            smiOutData,
  output logic [PortIdWidth-1:0]          smiOutPortId,
  input  logic                            smiOutStop
);

  localparam int BufWidth = PortIdWidth + SmiEofcWidth + DataWidth;

  arbState_t                state_q;
  arbState_t                stateNext;
  logic [PortIdWidth-1:0]   grant_q;
  logic [PortIdWidth-1:0]   lastGrant_q;
  logic [PortIdWidth-1:0]   pickIdx;
  logic                     anyReq;
  logic                     grantReady;
  logic [SmiEofcWidth-1:0]  grantEofc;
  logic [DataWidth-1:0]     grantData;
  logic                     accept;
  logic                     acceptEof;
  logic                     bufFull_q;
  logic                     bufEmpty_q;
  logic [BufWidth-1:0]      bufHead;

  // Round-robin search: first requester above the last granted port, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    idx     = 0;
    pickIdx = '0;
    for (int i = 1; i <= NumPorts; i++) begin
      idx = (int'(lastGrant_q) + i) % NumPorts;
      if (!found && smiInReady[idx]) begin
        found   = 1'b1;
        pickIdx = PortIdWidth'(idx);
      end
    end
  end

  // Select the granted port's word and decide whether it is taken this cycle.
  always_comb begin
    anyReq     = |smiInReady;
    grantReady = smiInReady[grant_q];
    grantEofc  = smiInEofc[int'(grant_q)*SmiEofcWidth +: SmiEofcWidth];
    grantData  = smiInData[int'(grant_q)*DataWidth +: DataWidth];
    accept     = (state_q == ArbForward) && grantReady && !bufFull_q;
    acceptEof  = accept && smiIsEof(grantEofc);
  end

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ArbIdle;
    end else begin
      state_q <= stateNext;
    end
  end

  // Next state: grab a port when anyone asks, release after the EOF word.
  always_comb begin
    stateNext = state_q;
    unique case (state_q)
      ArbIdle: begin
        if (anyReq) begin
          stateNext = ArbForward;
        end
      end
      ArbForward: begin
        if (acceptEof) begin
          stateNext = ArbIdle;
        end
      end
      default: stateNext = ArbIdle;
    endcase
  end

  // Grant bookkeeping; lastGrant resets to the top port so port 0 wins first.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      grant_q     <= '0;
      lastGrant_q <= PortIdWidth'(NumPorts - 1);
    end else begin
      if (state_q == ArbIdle && anyReq) begin
        grant_q <= pickIdx;
      end
      if (acceptEof) begin
        lastGrant_q <= grant_q;
      end
    end
  end

  // Upstream stops depend only on registered state: everyone is held off
  // except the granted port, which sees the buffer's registered full flag.
  always_comb begin
    smiInStop = '1;
    if (state_q == ArbForward) begin
      smiInStop[grant_q] = bufFull_q;
    end
  end

  smi_skid_buffer #(
    .Width(BufWidth)
  ) uOutBuf (
    .clk      (clk),
    .rstN     (rstN),
    .pushEn   (accept),
    .pushData ({grant_q, grantEofc, grantData}),
    .popEn    (!smiOutStop),
    .headData (bufHead),
    .full     (bufFull_q),
    .empty    (bufEmpty_q)
  );

  assign smiOutReady  = !bufEmpty_q;
  assign smiOutPortId = bufHead[BufWidth-1 -: PortIdWidth];
  assign smiOutEofc   = bufHead[DataWidth +: SmiEofcWidth];
  assign smiOutData   = bufHead[DataWidth-1:0];

endmodule

// File: tb/tb_smi_frame_arbiter.sv
// Bench for smi_frame_arbiter: per-port source queues, an ownership-level
// reference model with an expected output queue, directed then random traffic.
module tb_smi_frame_arbiter;

  localparam int NumPorts    = 4;
  localparam int PortIdWidth = 2;
  localparam int DataWidth   = 128;
  localparam int WordW       = 8 + DataWidth;
  localparam int ExpW        = PortIdWidth + WordW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic [NumPorts-1:0]           smiInReady;
  logic [NumPorts*8-1:0]         smiInEofc;
  logic [NumPorts*DataWidth-1:0] smiInData;
  logic [NumPorts-1:0]           smiInStop;
  logic                          smiOutReady;
  logic [7:0]                    smiOutEofc;
  logic [DataWidth-1:0]          smiOutData;
  logic [PortIdWidth-1:0]        smiOutPortId;
  logic                          smiOutStop;

  smi_frame_arbiter #(
    .NumPorts(NumPorts), .PortIdWidth(PortIdWidth), .DataIndexSize(4)
  ) dut (
    .clk(clk), .rstN(rstN),
    .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData),
    .smiInStop(smiInStop),
    .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData),
    .smiOutPortId(smiOutPortId), .smiOutStop(smiOutStop)
  );

  // ---------------- bench state ----------------
  logic [WordW-1:0] srcQ [NumPorts][$];
  logic [ExpW-1:0]  exp_q[$];
  logic [NumPorts-1:0] paused;
  int outStopMode;   // 0 never stall, 1 always stall, 2 random
  int assertions = 0;
  int failures = 0;

  // Model: who owns the channel and who owned it last.
  bit mOwned;
  int mOwner;
  int mLast;

  task automatic check(input string tag, input logic [ExpW-1:0] got, input logic [ExpW-1:0] exp);
    assertions++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int rrPick(input int last, input logic [NumPorts-1:0] req);
    for (int i = 1; i <= NumPorts; i++) begin
      int q;
      q = (last + i) % NumPorts;
      if (req[q]) return q;
    end
    return 0;
  endfunction

  function automatic logic [DataWidth-1:0] randData();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic enqueueFrame(input int port, input int len, input logic [7:0] lastEofc);
    for (int i = 0; i < len; i++) begin
      srcQ[port].push_back({(i == len - 1) ? lastEofc : 8'h00, randData()});
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    for (int p = 0; p < NumPorts; p++) srcQ[p].delete();
    paused = '0;
    mOwned = 1'b0;
    mOwner = 0;
    mLast  = NumPorts - 1;
  endtask

  // ---------------- driver + model, one cycle ----------------
  task automatic tick();
    logic [NumPorts-1:0] expStop;
    logic [NumPorts-1:0] stopSeen;
    bit mAccept;
    bit mPop;
    for (int p = 0; p < NumPorts; p++) begin
      if (srcQ[p].size() > 0 && !paused[p]) begin
        smiInReady[p] = 1'b1;
        {smiInEofc[p*8 +: 8], smiInData[p*DataWidth +: DataWidth]} = srcQ[p][0];
      end else begin
        smiInReady[p] = 1'b0;
        smiInEofc[p*8 +: 8] = 8'h00;
        smiInData[p*DataWidth +: DataWidth] = '0;
      end
    end
    smiOutStop = (outStopMode == 1) ? 1'b1 :
                 (outStopMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    #2;
    expStop = '1;
    if (mOwned) expStop[mOwner] = (exp_q.size() == 2);
    check("in_stop", ExpW'(smiInStop), ExpW'(expStop));
    check("out_ready", ExpW'(smiOutReady), ExpW'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("out_word", {smiOutPortId, smiOutEofc, smiOutData}, exp_q[0]);
    stopSeen = smiInStop;
    mAccept = mOwned && smiInReady[mOwner] && exp_q.size() < 2;
    mPop    = exp_q.size() > 0 && !smiOutStop;
    @(posedge clk);
    if (mPop) void'(exp_q.pop_front());
    if (mAccept) begin
      exp_q.push_back({PortIdWidth'(mOwner), srcQ[mOwner][0]});
      if (srcQ[mOwner][0][WordW-1 -: 8] != 8'h00) begin
        mOwned = 1'b0;
        mLast  = mOwner;
      end
    end else if (!mOwned && |smiInReady) begin
      mOwned = 1'b1;
      mOwner = rrPick(mLast, smiInReady);
    end
    for (int p = 0; p < NumPorts; p++) begin
      if (smiInReady[p] && !stopSeen[p]) void'(srcQ[p].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input int limit);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      done = !mOwned && exp_q.size() == 0;
      for (int p = 0; p < NumPorts; p++) if (srcQ[p].size() != 0) done = 1'b0;
      if (!done) begin
        tick();
        n++;
      end
    end
    check("drain_timeout", ExpW'(done), ExpW'(1));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rstN = 1'b0;
    smiInReady = '0;
    smiInEofc = '0;
    smiInData = '0;
    smiOutStop = 1'b0;
    outStopMode = 0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    check("rst_out_ready", ExpW'(smiOutReady), ExpW'(0));
    check("rst_out_word", {smiOutPortId, smiOutEofc, smiOutData}, '0);
    check("rst_in_stop", ExpW'(smiInStop), ExpW'({NumPorts{1'b1}}));
    rstN = 1'b1;

    // Single port, one 3-word frame.
    enqueueFrame(0, 3, 8'h10);
    drain(40);

    // Ports 1 and 3 together: 1 first, then 3.
    enqueueFrame(1, 4, 8'h01);
    enqueueFrame(3, 3, 8'h02);
    drain(60);

    // Every port streaming single-word frames.
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < NumPorts; p++) enqueueFrame(p, 1, 8'(r + 1));
    end
    drain(100);

    // Downstream stall mid-frame.
    enqueueFrame(0, 8, 8'h05);
    ticks(3);
    outStopMode = 1;
    ticks(5);
    check("stall_full_stop", ExpW'(smiInStop[0]), ExpW'(1));
    outStopMode = 0;
    drain(60);

    // Granted port pauses mid-frame while port 2 waits.
    enqueueFrame(1, 6, 8'h07);
    ticks(3);
    paused[1] = 1'b1;
    enqueueFrame(2, 2, 8'h08);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("paused_other_stop", ExpW'(smiInStop[2]), ExpW'(1));
    end
    paused[1] = 1'b0;
    drain(60);

    // Random traffic, pauses and downstream stalls.
    outStopMode = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int p;
        p = $urandom_range(0, NumPorts - 1);
        if (srcQ[p].size() < 12) enqueueFrame(p, $urandom_range(1, 5), 8'($urandom_range(1, 255)));
      end
      if ($urandom_range(0, 15) == 0) paused[$urandom_range(0, NumPorts - 1)] ^= 1'b1;
      tick();
    end
    paused = '0;
    outStopMode = 0;
    drain(400);

    // Reset in the middle of a frame.
    enqueueFrame(2, 6, 8'h09);
    ticks(4);
    #2;
    rstN = 1'b0;
    #1;
    check("midrst_out_ready", ExpW'(smiOutReady), ExpW'(0));
    check("midrst_in_stop", ExpW'(smiInStop), ExpW'({NumPorts{1'b1}}));
    modelReset();
    smiInReady = '0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    enqueueFrame(3, 2, 8'h0A);
    enqueueFrame(0, 2, 8'h0B);
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/smi_frame_arbiter.md
# smi_frame_arbiter

Frame-atomic round-robin arbiter that shares one downstream SMI request channel, such as the AXI write adaptor's request input, between `NumPorts` upstream SMI requesters. A grant is held from a frame's first word until its end-of-frame word has been accepted, so frames are never interleaved. A 2-entry output buffer breaks every combinational path from `smiOutStop` to the upstream stops. The granted port index travels with each word so response routing can be added downstream.

## Interface
- `NumPorts`, 4: number of upstream requesters, 2..8.
- `PortIdWidth`, 2: width of the port index; must satisfy 2^PortIdWidth >= NumPorts.
- `DataIndexSize`, 4: log2 of bytes per SMI word.
- `DataWidth`, (1<<DataIndexSize)*8: derived word width.
- `clk` input 1: single clock; all state is on the rising edge.
- `rstN` input 1: reset, asynchronous, active-low.
- `smiInReady` input NumPorts: per-port word valid.
- `smiInEofc` input NumPorts*8: per-port end-of-frame control; port p occupies [p*8+7:p*8].
- `smiInData` input NumPorts*DataWidth: per-port data, packed the same way.
- `smiInStop` output NumPorts: per-port backpressure.
- `smiOutReady` output 1: downstream word valid.
- `smiOutEofc` output 8: downstream end-of-frame control.
- `smiOutData` output DataWidth: downstream data.
- `smiOutPortId` output PortIdWidth: index of the port that sourced the word.
- `smiOutStop` input 1: downstream backpressure.

## Operation
- Transfer rule: a word moves on any channel when Ready=1 and Stop=0 in the same cycle. Eofc!=0 marks the last word of a frame; a frame may be a single word.
- State machine `state_q`:
  - ArbIdle: if any `smiInReady` bit is set, pick the first set bit searching upward from `lastGrant_q+1` modulo NumPorts, register it in `grant_q`, and go to ArbForward. With no request, stay in ArbIdle.
  - ArbForward: `smiInStop[grant_q] = bufFull_q`. Each accepted word is pushed into the output buffer tagged with `grant_q`. When an accepted word has Eofc!=0, set `lastGrant_q <= grant_q` and go to ArbIdle.
- Every non-granted port, and every port while in ArbIdle, sees Stop=1.
- If the granted port drops Ready mid-frame, the grant is held indefinitely. There is no timeout.
- Output buffer:
  - 2 entries, FIFO order; the head drives `smiOut*`.
  - `bufFull_q` is registered and equals count==2.
  - Simultaneous push and pop with count 1 or 2 leaves the count unchanged.
  - Push with count 0 makes the word visible on the next cycle.
- Reset values:
  - `smiOutReady`=0, `smiOutEofc`=0, `smiOutData`=0, `smiOutPortId`=0.
  - `smiInStop` all 1.
  - `state_q`=ArbIdle, `lastGrant_q`=NumPorts-1, so port 0 wins first.
  - Buffer empty.
- Reset mid-frame clears all state immediately. Partial frames are discarded, and upstream and downstream must be reset together.

## Timing
- Request latency: `smiInReady[p]` rises in cycle N while in ArbIdle → `smiInStop[p]`=0 in N+1 → first word appears on `smiOutReady` in N+2.
- Throughput: 1 word/cycle within a frame while the downstream does not stall.
- Frame switch: the cycle after the EOF word is accepted is an ArbIdle cycle and the next grant takes effect one cycle later. The result is exactly one upstream bubble between back-to-back frames.
- `smiInStop` is a function of registered state only. There is no combinational path from `smiOutStop` or any `smiInReady` to any `smiInStop`.
- `smiOut*` are driven directly from buffer registers.

## Structure
- Shared package `smi_pkg`:
  - SMI Eofc width (8).
  - `smiIsEof(eofc)` helper (eofc != 0).
  - Frame type ID byte constants (write response 8'hFE).
  - Arbiter state encoding (ArbIdle=0, ArbForward=1).
- Sub-module `smi_skid_buffer`: 2-entry, parameterised width, registered full and empty flags, reused for the data+eofc+portId bundle.
- The round-robin search stays inline in the arbiter.

## Test plan
- Single port 0, one 3-word frame (Eofc 0,0,16) → words out at cycles 2,3,4 after request, `smiOutPortId`=0, all other Stops held at 1.
- Ports 1 and 3 request simultaneously after reset → port 1 granted first, then port 3 after port 1's EOF. `smiOutPortId` sequence 1,1,…,3, with no interleaving.
- All 4 ports send continuous 1-word frames → grant order 0,1,2,3,0,…, with exactly one idle cycle between frames.
- Downstream holds `smiOutStop`=1 for 5 cycles mid-frame → buffer fills to 2, granted Stop=1, no words lost or duplicated. Order is preserved on release.
- Granted port drops Ready for 4 cycles mid-frame while port 2 requests → port 2 stays stopped until the EOF of the current frame.
- Assert `rstN`=0 mid-frame → `smiOutReady`=0 and all Stops=1 in the same cycle. After release, port 0 wins first.
